// File: rtl/pic_pkg.sv
// Shared constants and helpers for the priority interrupt controller.
// Optional AUTO_EOI_EN build macro is consumed by priority_interrupt_controller.
package pic_pkg;

    localparam int          PIC_NUM_IRQ = 8;

    localparam logic [1:0]  PIC_IMR     = 2'd0;
    localparam logic [1:0]  PIC_IRR     = 2'd1;
    localparam logic [1:0]  PIC_ISR     = 2'd2;
    localparam logic [1:0]  PIC_EOI     = 2'd3;

    localparam logic [11:0] PIC_BASE    = 12'ha00;

    // Index of the lowest set bit (bit 0 is highest priority); 32 when v is zero.
    function automatic int lowest_set(input logic [31:0] v);
        int idx;
        idx = 32;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_priority_enc.sv
// Lowest-set-bit priority encoder: valid flag plus index of the winning request.
module pic_priority_enc
    import pic_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = IW'(lowest_set(32'(req)));
    end

endmodule

// File: rtl/priority_interrupt_controller.sv
// Memory-mapped 8-input priority interrupt controller (IMR/IRR/ISR/EOI window).
// Define AUTO_EOI_EN to drop in-service tracking: acknowledge retires the request immediately.
module priority_interrupt_controller
    import pic_pkg::*;
#(
    parameter int          NUM_IRQ  = PIC_NUM_IRQ,
    parameter logic [15:0] VEC_BASE = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               intack,
    output logic               INT,
    output logic [15:0]        vector,
    input  logic               cs,
    input  logic [1:0]         a,
    input  logic               wr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata
);

    localparam int          IW           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [15:0] VEC_SPURIOUS = VEC_BASE + 16'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] imr, irr, isr, irq_q;
    logic               intack_q;
    logic [15:0]        vector_q;

    logic [NUM_IRQ-1:0] rise, eligible, irr_clr, ack_mask, eoi_mask;
    logic               el_valid, is_valid;
    logic [IW-1:0]      el_idx, is_idx;
    logic               ack_start, wr_en;
    logic [15:0]        ack_vector;
    logic               unused_wdata;

    assign unused_wdata = ^{wdata, 1'b0};

    pic_priority_enc #(.N(NUM_IRQ), .IW(IW)) u_enc_eligible (
        .req   (eligible),
        .valid (el_valid),
        .idx   (el_idx)
    );

    pic_priority_enc #(.N(NUM_IRQ), .IW(IW)) u_enc_isr (
        .req   (isr),
        .valid (is_valid),
        .idx   (is_idx)
    );

`ifdef AUTO_EOI_EN
    logic unused_isr;
    assign unused_isr = is_valid ^ (^is_idx);
`endif

    // During the first intack cycle the vector bypasses the register so the CPU can sample it at once.
    always_comb begin
        wr_en      = wr & cs;
        rise       = irq & ~irq_q;
        eligible   = irr & ~imr;
        ack_start  = intack & ~intack_q;
        ack_mask   = (ack_start && el_valid) ? (NUM_IRQ'(1) << el_idx) : '0;
        ack_vector = el_valid ? (VEC_BASE + 16'(el_idx)) : VEC_SPURIOUS;
        irr_clr    = (wr_en && a == PIC_IRR) ? wdata[NUM_IRQ-1:0] : '0;
`ifdef AUTO_EOI_EN
        eoi_mask   = '0;
        INT        = el_valid;
`else
        eoi_mask   = (wr_en && a == PIC_EOI && is_valid) ? (NUM_IRQ'(1) << is_idx) : '0;
        INT        = el_valid && (!is_valid || el_idx < is_idx);
`endif
        vector     = ack_start ? ack_vector : vector_q;
    end

    // A fresh rising edge is OR'd in last so it beats a same-cycle clear or acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            imr      <= '1;
            irr      <= '0;
            isr      <= '0;
            irq_q    <= '0;
            intack_q <= 1'b0;
            vector_q <= VEC_BASE;
        end else begin
            irq_q    <= irq;
            intack_q <= intack;
            if (wr_en && a == PIC_IMR) imr <= wdata[NUM_IRQ-1:0];
            irr      <= (irr & ~irr_clr & ~ack_mask) | rise;
`ifdef AUTO_EOI_EN
            isr      <= isr & ~eoi_mask;
`else
            isr      <= (isr & ~eoi_mask) | ack_mask;
`endif
            if (ack_start) vector_q <= ack_vector;
        end
    end

    always_comb begin
        rdata = '0;
        if (cs) begin
            case (a)
                PIC_IMR: rdata = 16'(imr);
                PIC_IRR: rdata = 16'(irr);
                PIC_ISR: rdata = 16'(isr);
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_interrupt_controller.sv
// Self-checking bench for priority_interrupt_controller: directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_priority_interrupt_controller;

`ifdef AUTO_EOI_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        bit        rst;
        bit [7:0]  irq;
        bit        intack;
        bit        cs;
        bit [1:0]  a;
        bit        wr;
        bit [15:0] wdata;
        bit        chk;
        bit        e_int;
        bit [15:0] e_vec;
        bit [15:0] e_rd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [7:0]  irq;
    logic        intack;
    logic        int_req;
    logic [15:0] vector;
    logic        cs;
    logic [1:0]  a;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain bit sets.
    bit [7:0]  m_imr, m_irr, m_isr, m_irq_q;
    bit        m_intack_q;
    bit [15:0] m_vec;

    vec_t tbl[$];

    priority_interrupt_controller #(.NUM_IRQ(8), .VEC_BASE(16'h0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .intack (intack),
        .INT    (int_req),
        .vector (vector),
        .cs     (cs),
        .a      (a),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic vec_t mk(input bit r, input bit [7:0] q, input bit ia, input bit c,
                                input bit [1:0] ad, input bit w, input bit [15:0] wd,
                                input bit ck, input bit ei, input bit [15:0] ev, input bit [15:0] er);
        vec_t v;
        v.rst = r; v.irq = q; v.intack = ia; v.cs = c; v.a = ad; v.wr = w; v.wdata = wd;
        v.chk = ck; v.e_int = ei; v.e_vec = ev; v.e_rd = er;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst    = v.rst;
        irq    = v.irq;
        intack = v.intack;
        cs     = v.cs;
        a      = v.a;
        wr     = v.wr;
        wdata  = v.wdata;
        #2;
    endtask

    // Advance the model across the edge using the inputs that were applied.
    task automatic modelUpdate();
        bit [7:0] nirr, nisr;
        int       sel, eidx;
        bit       first;
        if (rst) begin
            m_imr = 8'hff; m_irr = '0; m_isr = '0; m_irq_q = '0; m_intack_q = 1'b0; m_vec = 16'h0000;
            return;
        end
        first = intack && !m_intack_q;
        sel   = lowest(m_irr & ~m_imr);
        eidx  = lowest(m_isr);
        nirr  = m_irr;
        nisr  = m_isr;
        if (cs && wr) begin
            case (a)
                2'd0: m_imr = wdata[7:0];
                2'd1: nirr = nirr & ~wdata[7:0];
                2'd3: if (!AUTO && eidx < 8) nisr[eidx] = 1'b0;
                default: ;
            endcase
        end
        if (first) begin
            if (sel < 8) begin
                nirr[sel] = 1'b0;
                if (!AUTO) nisr[sel] = 1'b1;
                m_vec = 16'(sel);
            end else begin
                m_vec = 16'd7;
            end
        end
        for (int i = 0; i < 8; i++) if (irq[i] && !m_irq_q[i]) nirr[i] = 1'b1;
        m_irr = nirr; m_isr = nisr; m_irq_q = irq; m_intack_q = intack;
    endtask

    task automatic checkModel(input int cyc);
        int        e, s;
        bit        exp_int;
        bit [15:0] exp_vec, exp_rd;
        e = lowest(m_irr & ~m_imr);
        s = lowest(m_isr);
        exp_int = AUTO ? (e < 8) : (e < 8 && e < s);
        exp_vec = (intack && !m_intack_q) ? ((e < 8) ? 16'(e) : 16'd7) : m_vec;
        exp_rd  = 16'h0000;
        if (cs) begin
            case (a)
                2'd0: exp_rd = {8'h00, m_imr};
                2'd1: exp_rd = {8'h00, m_irr};
                2'd2: exp_rd = {8'h00, m_isr};
                default: exp_rd = 16'h0000;
            endcase
        end
        checkOutput($sformatf("rnd%0d_int", cyc), {15'b0, int_req}, {15'b0, exp_int});
        checkOutput($sformatf("rnd%0d_vec", cyc), vector, exp_vec);
        checkOutput($sformatf("rnd%0d_rdata", cyc), rdata, exp_rd);
    endtask

    task automatic runRow(input vec_t v, input string tag);
        applyStimulus(v);
        if (v.chk) begin
            checkOutput({tag, "_int"}, {15'b0, int_req}, {15'b0, v.e_int});
            checkOutput({tag, "_vec"}, vector, v.e_vec);
            checkOutput({tag, "_rdata"}, rdata, v.e_rd);
        end
        @(posedge clk);
        #1;
        modelUpdate();
    endtask

    initial begin
        vec_t v;
        bit   iack;
        rst = 1'b1; irq = '0; intack = 1'b0; cs = 1'b0; a = '0; wr = 1'b0; wdata = '0;

`ifndef AUTO_EOI_EN
        //                rst irq    ack cs a  wr wdata      chk INT vec       rdata
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h00ff));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h00ff));
        tbl.push_back(mk(0, 8'h04, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h04, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h0004));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 1, 16'h0002, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 0, 16'h0002, 16'h0004));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0002, 16'h0000));
        tbl.push_back(mk(0, 8'h22, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000));
        tbl.push_back(mk(0, 8'h22, 1, 1, 1, 0, 16'h0000, 1, 1, 16'h0001, 16'h0022));
        tbl.push_back(mk(0, 8'h22, 1, 1, 2, 0, 16'h0000, 1, 0, 16'h0001, 16'h0002));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0001, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 1, 16'h0001, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 16'h0000, 1, 1, 16'h0005, 16'h0020));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0005, 16'h0020));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0005, 16'h0000));
        tbl.push_back(mk(0, 8'h10, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0005, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 1, 16'h0004, 16'h0000));
        tbl.push_back(mk(0, 8'h01, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0004, 16'h0010));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0004, 16'h0001));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0011));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0010));
        tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 16'h0008, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h08, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h08, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0008));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0008));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0000, 16'h0008));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 16'h0008, 1, 1, 16'h0000, 16'h0008));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 16'h0000, 1, 0, 16'h0007, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 0, 16'h0007, 16'h0000));
        tbl.push_back(mk(0, 8'h40, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0007, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0007, 16'h0040));
        tbl.push_back(mk(0, 8'h40, 0, 1, 1, 1, 16'h0040, 1, 1, 16'h0007, 16'h0040));
        tbl.push_back(mk(0, 8'h40, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0007, 16'h0040));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 0, 16'h0006, 16'h0040));
        tbl.push_back(mk(1, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 0, 16'h0006, 16'h0040));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h00ff));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(1, 8'h01, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0001));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000));
        for (int i = 0; i < tbl.size(); i++) runRow(tbl[i], $sformatf("tbl%0d", i));

        // Acknowledge and EOI in the same cycle, then EOI with nothing in service.
        runRow(mk(1, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000), "seqA0");
        runRow(mk(0, 8'h00, 0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h00ff), "seqA1");
        runRow(mk(0, 8'h10, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000), "seqA2");
        runRow(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 1, 16'h0004, 16'h0000), "seqA3");
        runRow(mk(0, 8'h01, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0004, 16'h0010), "seqA4");
        runRow(mk(0, 8'h00, 1, 1, 3, 1, 16'h0000, 1, 1, 16'h0000, 16'h0000), "seqA5");
        runRow(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0001), "seqA6");
        runRow(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000), "seqA7");
        runRow(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000), "seqA8");
        runRow(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000), "seqA9");
`else
        // Auto-EOI: acknowledges never set ISR and lower-priority requests are not held off.
        runRow(mk(1, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000), "seqB0");
        runRow(mk(0, 8'h00, 0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h00ff), "seqB1");
        runRow(mk(0, 8'h04, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000), "seqB2");
        runRow(mk(0, 8'h00, 1, 1, 2, 0, 16'h0000, 1, 1, 16'h0002, 16'h0000), "seqB3");
        runRow(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000), "seqB4");
        runRow(mk(0, 8'h22, 0, 1, 1, 0, 16'h0000, 1, 0, 16'h0002, 16'h0000), "seqB5");
        runRow(mk(0, 8'h00, 0, 1, 1, 0, 16'h0000, 1, 1, 16'h0002, 16'h0022), "seqB6");
        runRow(mk(0, 8'h00, 1, 1, 1, 0, 16'h0000, 1, 1, 16'h0001, 16'h0022), "seqB7");
        runRow(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 1, 16'h0001, 16'h0000), "seqB8");
        runRow(mk(0, 8'h00, 0, 1, 3, 1, 16'h0000, 1, 1, 16'h0001, 16'h0000), "seqB9");
        runRow(mk(0, 8'h00, 0, 1, 2, 0, 16'h0000, 1, 1, 16'h0001, 16'h0000), "seqB10");
`endif

        // Randomized traffic checked against the model every cycle.
        runRow(mk(1, 8'h00, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000), "rnd_rst");
        iack = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v.rst = ($urandom_range(0, 99) == 0);
            v.irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if (iack) iack = ($urandom_range(0, 1) == 0);
            else      iack = ($urandom_range(0, 3) == 0);
            v.intack = iack;
            v.cs     = ($urandom_range(0, 1) == 1);
            v.a      = 2'($urandom_range(0, 3));
            v.wr     = v.cs && ($urandom_range(0, 2) == 0);
            v.wdata  = 16'($urandom);
            if (v.a == 2'd0 && $urandom_range(0, 3) != 0) v.wdata = 16'($urandom) & 16'h0011;
            applyStimulus(v);
            checkModel(cyc);
            @(posedge clk);
            #1;
            modelUpdate();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
